// File: rtl/input_skew_feeder_pkg.sv
// Shared FSM encoding and lane/vector width constants for the systolic feed path.
package systolic_pkg;

    localparam int unsigned ArrayWidthDef = 4;
    localparam int unsigned DataSizeDef   = 8;
    localparam int unsigned DepthDef      = 16;

    localparam int unsigned LaneW = DataSizeDef;
    localparam int unsigned VecW  = ArrayWidthDef * DataSizeDef;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2
    } feed_state_e;

    function automatic int unsigned vec_width(int unsigned lanes, int unsigned lane_w);
        return lanes * lane_w;
    endfunction

endpackage

// File: rtl/input_skew_feeder_if.sv
// Load/stream/output bundle of the input skew feeder.
// INPUT_BUF_REPLAY_EN adds the flush request.
interface input_skew_feeder_if
    import systolic_pkg::*;
#(
    parameter int unsigned ARRAYWIDTH = ArrayWidthDef,
    parameter int unsigned DATASIZE   = DataSizeDef,
    parameter int unsigned DEPTH      = DepthDef
);
    logic                             in_valid;
    logic                             in_ready;
    logic [ARRAYWIDTH*DATASIZE-1:0]   in_vec;
    logic                             start;
    logic                             busy;
    logic                             done;
    logic [$clog2(DEPTH+1)-1:0]       count;
    logic [ARRAYWIDTH*DATASIZE-1:0]   out_vec;
    logic [ARRAYWIDTH-1:0]            out_valid;
`ifdef INPUT_BUF_REPLAY_EN
    logic                             flush;

    modport master (
        output in_valid, in_vec, start, flush,
        input  in_ready, busy, done, count, out_vec, out_valid
    );
    modport slave (
        input  in_valid, in_vec, start, flush,
        output in_ready, busy, done, count, out_vec, out_valid
    );
`else
    modport master (
        output in_valid, in_vec, start,
        input  in_ready, busy, done, count, out_vec, out_valid
    );
    modport slave (
        input  in_valid, in_vec, start,
        output in_ready, busy, done, count, out_vec, out_valid
    );
`endif
endinterface

// File: rtl/input_skew_feeder_skew.sv
// Fixed-length data+valid delay line; one per lane gives the diagonal skew.
module skew_delay_line #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned STAGES   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] data_i,
    input  logic                valid_i,
    output logic [DATASIZE-1:0] data_o,
    output logic                valid_o
);
    logic [DATASIZE-1:0] data_q [STAGES];
    logic [STAGES-1:0]   valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(STAGES); s++) data_q[s] <= '0;
            valid_q <= '0;
        end else begin
            data_q[0]  <= data_i;
            valid_q[0] <= valid_i;
            for (int s = 1; s < int'(STAGES); s++) begin
                data_q[s]  <= data_q[s-1];
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    assign data_o  = data_q[STAGES-1];
    assign valid_o = valid_q[STAGES-1];

endmodule

// File: rtl/input_skew_feeder.sv
// Buffers operand vectors, then streams them paced by DSP_DELAY with lane i delayed i cycles.
// INPUT_BUF_REPLAY_EN: streaming keeps the buffer (tile replay) and adds flush.
module input_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned ARRAYWIDTH = ArrayWidthDef,
    parameter int unsigned DATASIZE   = DataSizeDef,
    parameter int unsigned DEPTH      = DepthDef,
    parameter int unsigned DSP_DELAY  = 1
) (
    input logic                clk,
    input logic                rst,
    input_skew_feeder_if.slave bus_io
);
    localparam int unsigned VW     = vec_width(ARRAYWIDTH, DATASIZE);
    localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam int unsigned PaceW  = (DSP_DELAY > 1) ? $clog2(DSP_DELAY) : 1;
    localparam int unsigned DrainW = (ARRAYWIDTH > 1) ? $clog2(ARRAYWIDTH) : 1;

    feed_state_e       state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr;
    logic [CntW-1:0]   count_q, count_d;
    logic [PaceW-1:0]  pace_q, pace_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic              done_q, done_d;
    logic              in_ready, busy, wr_en, issue, last_issue, drain_end, flush_en;
    logic [VW-1:0]     mem_q [DEPTH];
    logic [VW-1:0]     rd_vec, out_vec;
    logic [ARRAYWIDTH-1:0] out_valid;

`ifdef INPUT_BUF_REPLAY_EN
    logic [PtrW-1:0] idx_q, idx_d;

    // Replay walks an index from the fixed base so the buffer contents survive the stream.
    assign flush_en   = (state_q == StIdle) && bus_io.flush;
    assign last_issue = (CntW'(idx_q) + CntW'(1)) == count_q;
    assign rd_addr    = rd_ptr_q + idx_q;
`else
    assign flush_en   = 1'b0;
    assign last_issue = count_q == CntW'(1);
    assign rd_addr    = rd_ptr_q;
`endif

    assign wr_en     = bus_io.in_valid && in_ready && !flush_en;
    assign issue     = (state_q == StStream) && (pace_q == '0);
    assign drain_end = (state_q == StDrain) && (drain_q == DrainW'(ARRAYWIDTH - 1));
    assign rd_vec    = mem_q[rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus_io.start && (count_d != '0)) state_d = StStream;
            StStream: if (issue && last_issue) state_d = StDrain;
            StDrain:  if (drain_end) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = state_q != StIdle;
        in_ready = (state_q == StIdle) && (count_q < CntW'(DEPTH));
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pace_d   = pace_q;
        drain_d  = drain_q;
        done_d   = drain_end;
`ifdef INPUT_BUF_REPLAY_EN
        idx_d    = idx_q;
`endif
        unique case (state_q)
            StIdle: begin
                pace_d  = '0;
                drain_d = '0;
                if (flush_en) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + PtrW'(1);
                    count_d  = count_q + CntW'(1);
                end
            end
            StStream: begin
                if (issue) begin
                    pace_d = PaceW'(DSP_DELAY - 1);
`ifdef INPUT_BUF_REPLAY_EN
                    idx_d  = last_issue ? '0 : idx_q + PtrW'(1);
`else
                    rd_ptr_d = rd_ptr_q + PtrW'(1);
                    count_d  = count_q - CntW'(1);
`endif
                end else begin
                    pace_d = pace_q - PaceW'(1);
                end
            end
            StDrain: drain_d = drain_q + DrainW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pace_q   <= '0;
            drain_q  <= '0;
            done_q   <= 1'b0;
`ifdef INPUT_BUF_REPLAY_EN
            idx_q    <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pace_q   <= pace_d;
            drain_q  <= drain_d;
            done_q   <= done_d;
`ifdef INPUT_BUF_REPLAY_EN
            idx_q    <= idx_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus_io.in_vec;
    end

    // Words enter the delay lines zeroed when not issued, so idle lanes pad with zero.
    for (genvar i = 0; i < ARRAYWIDTH; i++) begin : g_lane
        logic [DATASIZE-1:0] word;
        assign word = issue ? rd_vec[i*DATASIZE +: DATASIZE] : '0;

        skew_delay_line #(
            .DATASIZE (DATASIZE),
            .STAGES   (i + 1)
        ) u_line (
            .clk     (clk),
            .rst     (rst),
            .data_i  (word),
            .valid_i (issue),
            .data_o  (out_vec[i*DATASIZE +: DATASIZE]),
            .valid_o (out_valid[i])
        );
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.busy      = busy;
    assign bus_io.done      = done_q;
    assign bus_io.count     = count_q;
    assign bus_io.out_vec   = out_vec;
    assign bus_io.out_valid = out_valid;

endmodule
